// File: rtl/i3c_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i3c_ram_arb_pkg
// Brief    : Shared requester count and index type for the 1-port RAM arbiter
// Revision : 1.0
// ============================================================================
package i3c_ram_arb_pkg;

  localparam int unsigned c_num_req = 2;

  typedef logic [$clog2(c_num_req)-1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/i3c_ram_1p_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i3c_ram_1p_arbiter
// Brief    : Two-requester round-robin arbiter in front of a single-port RAM
// Revision : 1.0
// ============================================================================
module i3c_ram_1p_arbiter
  import i3c_ram_arb_pkg::*;
#(
  parameter  int unsigned Width = 32,
  parameter  int unsigned Depth = 128,
  localparam int unsigned Aw    = $clog2(Depth)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [c_num_req-1:0]             req_i,
  input  logic [c_num_req-1:0]             write_i,
  input  logic [c_num_req-1:0][Aw-1:0]     addr_i,
  input  logic [c_num_req-1:0][Width-1:0]  wdata_i,
  input  logic [c_num_req-1:0][Width-1:0]  wmask_i,
  output logic [c_num_req-1:0]             gnt_o,
  output logic [c_num_req-1:0]             rvalid_o,
  output logic [Width-1:0]                 rdata_o,
  output logic [c_num_req-1:0]             err_o,
  output logic                             ram_req_o,
  output logic                             ram_write_o,
  output logic [Aw-1:0]                    ram_addr_o,
  output logic [Width-1:0]                 ram_wdata_o,
  output logic [Width-1:0]                 ram_wmask_o,
  input  logic [Width-1:0]                 ram_rdata_i
);

  req_idx_t             last_q;
  req_idx_t             w_sel;
  logic [c_num_req-1:0] w_gnt;
  logic                 w_any;
  logic                 w_in_range;
  logic                 w_ram_req;
  logic [c_num_req-1:0] r_rvalid;
  logic [c_num_req-1:0] r_err;

  // On conflict the port that did not win last time goes first.
  always_comb begin
    w_gnt = '0;
    w_sel = req_idx_t'(0);
    if (!rst_i) begin
      if (&req_i)         w_sel = ~last_q;
      else if (req_i[1])  w_sel = req_idx_t'(1);
      w_gnt[w_sel] = |req_i;
    end
  end

  assign w_any      = |w_gnt;
  assign w_in_range = 32'(addr_i[w_sel]) < Depth;
  assign w_ram_req  = w_any && w_in_range;

  assign gnt_o       = w_gnt;
  assign ram_req_o   = w_ram_req;
  assign ram_write_o = w_ram_req && write_i[w_sel];
  assign ram_addr_o  = w_ram_req ? addr_i[w_sel]  : '0;
  assign ram_wdata_o = w_ram_req ? wdata_i[w_sel] : '0;
  assign ram_wmask_o = w_ram_req ? wmask_i[w_sel] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q   <= req_idx_t'(1);
      r_rvalid <= '0;
      r_err    <= '0;
    end else begin
      if (&req_i) last_q <= w_sel;
      r_rvalid <= (w_ram_req && !write_i[w_sel]) ? w_gnt : '0;
      r_err    <= (w_any && !w_in_range)         ? w_gnt : '0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = ram_rdata_i;

endmodule
`default_nettype wire

// File: doc/i3c_ram_1p_arbiter.md
I3C_RAM_1P_ARBITER -- requirements
Module: i3c_ram_1p_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, meaning RAM data width in bits.
REQ-002 SHALL have parameter Depth, default 128, meaning RAM word count.
REQ-003 SHALL have derived localparam Aw = $clog2(Depth), meaning address width.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port req_i, input, 2, meaning per-requester access request.
REQ-007 SHALL have port write_i, input, 2, meaning per-requester write (1) / read (0).
REQ-008 SHALL have port addr_i, input, 2 x Aw, meaning per-requester word address.
REQ-009 SHALL have port wdata_i, input, 2 x Width, meaning per-requester write data.
REQ-010 SHALL have port wmask_i, input, 2 x Width, meaning per-requester full bit write mask.
REQ-011 SHALL have port gnt_o, output, 2, meaning request accepted this cycle.
REQ-012 SHALL have port rvalid_o, output, 2, meaning read data valid for that requester.
REQ-013 SHALL have port rdata_o, output, Width, meaning read data, shared by both requesters.
REQ-014 SHALL have port err_o, output, 2, meaning out-of-range address pulse.
REQ-015 SHALL have ports ram_req_o (1), ram_write_o (1), ram_addr_o (Aw), ram_wdata_o (Width), ram_wmask_o (Width), outputs, meaning the single-port RAM request side.
REQ-016 SHALL have port ram_rdata_i, input, Width, meaning RAM read data returned one cycle after ram_req_o.

Function
REQ-017 SHALL grant at most one requester per cycle; gnt_o is combinational from req_i and the priority register.
REQ-018 SHALL grant the only requesting port when exactly one req_i bit is high.
REQ-019 SHALL, when both req_i bits are high, grant the port not in register last_q (round-robin) and set last_q to the granted index on that edge.
REQ-020 SHALL leave last_q unchanged in cycles with no conflict.
REQ-021 SHALL drive ram_req_o high only when a grant is issued with an in-range address (addr < Depth), muxing write/addr/wdata/wmask from the granted port; RAM outputs SHALL be 0 otherwise.
REQ-022 SHALL, for an out-of-range granted address, still assert gnt_o, suppress ram_req_o, and pulse err_o[k] for one cycle on the following cycle.
REQ-023 SHALL assert rvalid_o[k] exactly one cycle after an in-range granted read from port k; no rvalid for writes or errored reads.
REQ-024 SHALL pass rdata_o = ram_rdata_i combinationally; rdata_o is meaningful only while some rvalid_o bit is high.
REQ-025 SHALL sustain one access per cycle back to back, including alternating ports and read-after-write to the same address (read returns new data).
REQ-026 SHALL require a requester to hold req_i and its payload stable until gnt_o; a withdrawn ungranted request is legal and causes no side effects.
REQ-027 SHALL never assert both rvalid_o bits or both gnt_o bits in one cycle.

Reset
REQ-028 SHALL, while rst_i is high, force last_q = 1 (port 0 wins first conflict), rvalid_o = 0, and err_o = 0.
REQ-029 SHALL gate gnt_o and ram_req_o to 0 while rst_i is high.
REQ-030 SHALL drop an in-flight read return (no rvalid_o) when rst_i asserts between grant and return.

Structure
REQ-031 SHALL place requester count (2) and the requester-index typedef in shared package i3c_ram_arb_pkg.
REQ-032 SHALL need no sub-module; the RAM (prim_generic_ram_1p) is instantiated by the parent and connected to the ram_* ports.

Verification
REQ-033 SHALL cover: port 0 writes 0xDEADBEEF to addr 5, mask all-ones, then reads addr 5 -> gnt_o[0] each cycle, rvalid_o[0] the cycle after the read, rdata_o = 0xDEADBEEF.
REQ-034 SHALL cover: both ports request reads continuously from reset -> grants alternate 0,1,0,1 and rvalid_o follows one cycle later on the matching bit.
REQ-035 SHALL cover: port 1 writes 0x0000FFFF with mask 0x0000FFFF over 0x12345678 at addr 3, then reads it -> rdata_o = 0x1234FFFF.
REQ-036 SHALL cover: Depth = 100, port 0 reads addr 120 -> gnt_o[0] = 1, ram_req_o = 0, err_o[0] pulses next cycle, no rvalid_o.
REQ-037 SHALL cover: rst_i asserted the cycle after a granted read of port 1 -> no rvalid_o[1]; after release, first conflict is granted to port 0.
REQ-038 SHALL cover: port 0 write and port 1 read to addr 7 in the same cycle with last_q = 0 -> port 1 is granted first and reads old data; the port 0 write is granted on the next cycle.
